ram_arbiter: RTL and testbench



---
 rtl/ram_arb_pkg.sv | 40 ++++
 rtl/ram_arbiter_rd_tag_fifo.sv | 58 +++++
 rtl/ram_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_ram_arbiter.sv | 397 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// Shared definitions for the SDRAM command-port arbiter: requester ids,
// read-tag encodings, FSM state encoding and the winner search helper.
package ram_arb_pkg;

  // Requester ids, also the search order of the fixed-priority arbiter
  localparam logic [1:0] REQ_CAM  = 2'd0;
  localparam logic [1:0] REQ_VGA  = 2'd1;
  localparam logic [1:0] REQ_HDRW = 2'd2;
  localparam logic [1:0] REQ_HDRR = 2'd3;

  // Read tags stored in the outstanding-read FIFO
  localparam logic TAG_HDR = 1'b0;
  localparam logic TAG_VGA = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    ACK   = 2'd2
  } arb_state_t;

  // Returns {found, id}: first eligible requester scanning upwards from
  // start with wrap-around, so start=REQ_CAM gives plain fixed priority.
  function automatic logic [2:0] pick_req(input logic [3:0] elig,
                                          input logic [1:0] start);
    logic       found;
    logic [1:0] id;
    logic [1:0] idx;
    found = 1'b0;
    id    = start;
    for (int k = 0; k < 4; k++) begin
      idx = start + 2'(k);
      if (!found && elig[idx]) begin
        found = 1'b1;
        id    = idx;
      end
    end
    return {found, id};
  endfunction

endpackage

// File: rtl/ram_arbiter_rd_tag_fifo.sv
// Outstanding-read tag FIFO: one bit per read in flight, popped in issue
// order as read beats come back. DEPTH must be a power of two so the
// pointers wrap naturally.
module rd_tag_fifo
  import ram_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     push_tag,
  input  logic                     pop,
  output logic                     pop_tag,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  // A pop in the same cycle frees the slot a full FIFO would otherwise lack
  assign push_ok = push && (!full || pop);
  assign pop_ok  = pop && !empty;
  assign pop_tag = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; reset discards every pending tag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Tag storage; contents are only meaningful below the count, so no reset
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_tag;
  end

endmodule

// File: rtl/ram_arbiter.sv
// Four-way arbiter in front of the single SDRAM controller command port.
// Serialises camera write, VGA read, HDR-result write and HDR-frame read
// commands, returns a one-cycle ack per grant and steers returned read
// beats back to their issuer through an outstanding-read tag FIFO.
// Build option ARB_ROUND_ROBIN_EN: rotating priority instead of the fixed
// camera > vga > hdr_wr > hdr_rd order.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W       = 25,
  parameter int DATA_W       = 128,
  parameter int RD_TAG_DEPTH = 4
) (
  input  logic              clk_133M,
  input  logic              rst_n_133M,

  input  logic              camera_wr_req,
  input  logic [ADDR_W-1:0] camera_wr_address,
  input  logic [DATA_W-1:0] camera_wr_data,
  output logic              camera_wr_ack,

  input  logic              vga_rd_req,
  input  logic [ADDR_W-1:0] vga_rd_address,
  output logic              vga_rd_ack,
  output logic              vga_rd_valid,

  input  logic              hdr_rd_req,
  input  logic [ADDR_W-1:0] hdr_rd_address,
  output logic              hdr_rd_ack,
  output logic              hdr_rd_valid,

  input  logic              hdr_wr_req,
  input  logic [ADDR_W-1:0] hdr_wr_address,
  input  logic [DATA_W-1:0] hdr_wr_data,
  output logic              hdr_wr_ack,

  input  logic              ram_busy,
  output logic              ram_cmd_valid,
  output logic              ram_cmd_we,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_wr_data,
  input  logic              ram_cmd_ack,
  input  logic              ram_rd_valid,

  output logic              tag_err
);

  localparam int CNT_W = $clog2(RD_TAG_DEPTH) + 1;

  arb_state_t       state;
  logic [1:0]       win_id;
  logic [3:0]       elig;
  logic [1:0]       search_start;
  logic [2:0]       pick_res;
  logic             pick_found;
  logic [1:0]       pick_id;

  logic             tag_push;
  logic             tag_push_val;
  logic             tag_pop_val;
  logic             tag_full;
  logic             tag_empty;
  // Occupancy is not needed by the arbiter itself; kept for debug probing
  logic [CNT_W-1:0] tag_count_unused;

  // Reads need a free tag slot before they may win; writes always may
  assign elig = {hdr_rd_req & ~tag_full,
                 hdr_wr_req,
                 vga_rd_req & ~tag_full,
                 camera_wr_req};

`ifdef ARB_ROUND_ROBIN_EN
  logic [1:0] rr_ptr;
  assign search_start = rr_ptr;
`else
  assign search_start = REQ_CAM;
`endif

  assign pick_res   = pick_req(elig, search_start);
  assign pick_found = pick_res[2];
  assign pick_id    = pick_res[1:0];

  // Tag is recorded exactly when the controller takes a read command
  assign tag_push     = (state == ISSUE) && ram_cmd_ack && !ram_cmd_we;
  assign tag_push_val = (win_id == REQ_VGA) ? TAG_VGA : TAG_HDR;

  rd_tag_fifo #(
    .DEPTH (RD_TAG_DEPTH)
  ) u_tag_fifo (
    .clk      (clk_133M),
    .rst_n    (rst_n_133M),
    .push     (tag_push),
    .push_tag (tag_push_val),
    .pop      (ram_rd_valid),
    .pop_tag  (tag_pop_val),
    .full     (tag_full),
    .empty    (tag_empty),
    .count    (tag_count_unused)
  );

  // Beat steering is combinational so the requester sees valid with the data
  assign vga_rd_valid = ram_rd_valid && !tag_empty && (tag_pop_val == TAG_VGA);
  assign hdr_rd_valid = ram_rd_valid && !tag_empty && (tag_pop_val == TAG_HDR);

  // Arbitration FSM: pick and latch in IDLE, hold command in ISSUE, ack in ACK
  always_ff @(posedge clk_133M) begin
    if (!rst_n_133M) begin
      state         <= IDLE;
      win_id        <= REQ_CAM;
      ram_cmd_valid <= 1'b0;
      ram_cmd_we    <= 1'b0;
      ram_address   <= '0;
      ram_wr_data   <= '0;
      camera_wr_ack <= 1'b0;
      vga_rd_ack    <= 1'b0;
      hdr_wr_ack    <= 1'b0;
      hdr_rd_ack    <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      rr_ptr        <= 2'd0;
`endif
    end else begin
      camera_wr_ack <= 1'b0;
      vga_rd_ack    <= 1'b0;
      hdr_wr_ack    <= 1'b0;
      hdr_rd_ack    <= 1'b0;
      case (state)
        IDLE: begin
          if (!ram_busy && pick_found) begin
            win_id        <= pick_id;
            ram_cmd_valid <= 1'b1;
            state         <= ISSUE;
            case (pick_id)
              REQ_CAM: begin
                ram_cmd_we  <= 1'b1;
                ram_address <= camera_wr_address;
                ram_wr_data <= camera_wr_data;
              end
              REQ_VGA: begin
                ram_cmd_we  <= 1'b0;
                ram_address <= vga_rd_address;
                ram_wr_data <= '0;
              end
              REQ_HDRW: begin
                ram_cmd_we  <= 1'b1;
                ram_address <= hdr_wr_address;
                ram_wr_data <= hdr_wr_data;
              end
              default: begin
                ram_cmd_we  <= 1'b0;
                ram_address <= hdr_rd_address;
                ram_wr_data <= '0;
              end
            endcase
          end
        end
        ISSUE: begin
          if (ram_cmd_ack) begin
            ram_cmd_valid <= 1'b0;
            state         <= ACK;
            case (win_id)
              REQ_CAM:  camera_wr_ack <= 1'b1;
              REQ_VGA:  vga_rd_ack    <= 1'b1;
              REQ_HDRW: hdr_wr_ack    <= 1'b1;
              default:  hdr_rd_ack    <= 1'b1;
            endcase
          end
        end
        ACK: begin
          // Ack pulse is visible during this state; req is resampled in IDLE
          state <= IDLE;
`ifdef ARB_ROUND_ROBIN_EN
          rr_ptr <= win_id + 2'd1;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Sticky flag for a read beat that arrives with no read outstanding
  always_ff @(posedge clk_133M) begin
    if (!rst_n_133M) begin
      tag_err <= 1'b0;
    end else if (ram_rd_valid && tag_empty) begin
      tag_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: requester/controller models, a
// negedge recorder feeding observation queues, and per-scenario tasks.
module tb_ram_arbiter;

  localparam int ADDR_W       = 25;
  localparam int DATA_W       = 128;
  localparam int RD_TAG_DEPTH = 4;

  logic              clk_133M = 1'b0;
  logic              rst_n_133M;
  logic              camera_wr_req, vga_rd_req, hdr_rd_req, hdr_wr_req;
  logic [ADDR_W-1:0] camera_wr_address, vga_rd_address, hdr_rd_address, hdr_wr_address;
  logic [DATA_W-1:0] camera_wr_data, hdr_wr_data;
  logic              camera_wr_ack, vga_rd_ack, hdr_rd_ack, hdr_wr_ack;
  logic              vga_rd_valid, hdr_rd_valid;
  logic              ram_busy, ram_cmd_valid, ram_cmd_we, ram_cmd_ack, ram_rd_valid;
  logic [ADDR_W-1:0] ram_address;
  logic [DATA_W-1:0] ram_wr_data;
  logic              tag_err;

  always #5 clk_133M = ~clk_133M;

  ram_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_TAG_DEPTH(RD_TAG_DEPTH)
  ) dut (
    .clk_133M(clk_133M), .rst_n_133M(rst_n_133M),
    .camera_wr_req(camera_wr_req), .camera_wr_address(camera_wr_address),
    .camera_wr_data(camera_wr_data), .camera_wr_ack(camera_wr_ack),
    .vga_rd_req(vga_rd_req), .vga_rd_address(vga_rd_address),
    .vga_rd_ack(vga_rd_ack), .vga_rd_valid(vga_rd_valid),
    .hdr_rd_req(hdr_rd_req), .hdr_rd_address(hdr_rd_address),
    .hdr_rd_ack(hdr_rd_ack), .hdr_rd_valid(hdr_rd_valid),
    .hdr_wr_req(hdr_wr_req), .hdr_wr_address(hdr_wr_address),
    .hdr_wr_data(hdr_wr_data), .hdr_wr_ack(hdr_wr_ack),
    .ram_busy(ram_busy), .ram_cmd_valid(ram_cmd_valid), .ram_cmd_we(ram_cmd_we),
    .ram_address(ram_address), .ram_wr_data(ram_wr_data),
    .ram_cmd_ack(ram_cmd_ack), .ram_rd_valid(ram_rd_valid), .tag_err(tag_err)
  );

  int errors = 0;
  int checks = 0;

  // Observations (filled by the recorder) and expectations (filled by tasks)
  int                got_grant[$];
  int                got_we[$];
  logic [ADDR_W-1:0] got_addr[$];
  int                got_beat[$];   // 0 = HDR, 1 = VGA, 2 = none, 3 = both
  int                exp_grant[$];
  int                exp_we[$];
  logic [ADDR_W-1:0] exp_addr[$];
  int                exp_beat[$];
  int                multi_ack = 0;
  bit                auto_ack  = 1'b0;
  bit                hold_reqs = 1'b0;
  bit                seen      = 1'b0;

  localparam logic [ADDR_W-1:0] CAM_A  = 25'h0ABCDE;
  localparam logic [ADDR_W-1:0] VGA_A  = 25'h1234567;
  localparam logic [ADDR_W-1:0] HDRR_A = 25'h0F0F0F0;
  localparam logic [ADDR_W-1:0] HDRW_A = 25'h1555AAA;
  localparam logic [DATA_W-1:0] CAM_D  = {4{32'hC0FFEE01}};
  localparam logic [DATA_W-1:0] HDRW_D = {4{32'h5A5A1234}};

  // Recorder, requester model (drop req on ack) and controller model
  initial begin
    forever begin
      @(negedge clk_133M);
      if ((int'(camera_wr_ack) + int'(vga_rd_ack) + int'(hdr_wr_ack) + int'(hdr_rd_ack)) > 1)
        multi_ack++;
      if (camera_wr_ack) begin got_grant.push_back(0); if (!hold_reqs) camera_wr_req = 1'b0; end
      if (vga_rd_ack)    begin got_grant.push_back(1); if (!hold_reqs) vga_rd_req    = 1'b0; end
      if (hdr_wr_ack)    begin got_grant.push_back(2); if (!hold_reqs) hdr_wr_req    = 1'b0; end
      if (hdr_rd_ack)    begin got_grant.push_back(3); if (!hold_reqs) hdr_rd_req    = 1'b0; end
      if (ram_rd_valid)
        got_beat.push_back((vga_rd_valid && hdr_rd_valid) ? 3 :
                           vga_rd_valid ? 1 : hdr_rd_valid ? 0 : 2);
      if (!auto_ack) begin
        seen = 1'b0;
      end else if (ram_cmd_valid && !ram_cmd_ack) begin
        if (seen) begin
          ram_cmd_ack = 1'b1;
          got_we.push_back(int'(ram_cmd_we));
          got_addr.push_back(ram_address);
        end else begin
          seen = 1'b1;
        end
      end else begin
        ram_cmd_ack = 1'b0;
        seen        = 1'b0;
      end
    end
  end

  function automatic int pop_grant();
    if (got_grant.size() == 0) return -1;
    return got_grant.pop_front();
  endfunction

  function automatic int pop_beat();
    if (got_beat.size() == 0) return -1;
    return got_beat.pop_front();
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk_133M);
    #1;
  endtask

  task automatic wait_grants(input int n, input int budget);
    int k = 0;
    while (got_grant.size() < n && k < budget) begin
      @(posedge clk_133M);
      k++;
    end
    #1;
  endtask

  task automatic rd_beat();
    ram_rd_valid = 1'b1;
    tick(1);
    ram_rd_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n_133M = 1'b0;
    camera_wr_req = 1'b0; vga_rd_req = 1'b0; hdr_rd_req = 1'b0; hdr_wr_req = 1'b0;
    ram_busy = 1'b0; ram_rd_valid = 1'b0; ram_cmd_ack = 1'b0;
    auto_ack = 1'b0; hold_reqs = 1'b0;
    tick(2);
    got_grant.delete(); got_we.delete(); got_addr.delete(); got_beat.delete();
    rst_n_133M = 1'b1;
    tick(1);
  endtask

  task automatic test_reset();
    camera_wr_address = CAM_A;  camera_wr_data = CAM_D;
    vga_rd_address    = VGA_A;  hdr_rd_address = HDRR_A;
    hdr_wr_address    = HDRW_A; hdr_wr_data    = HDRW_D;
    rst_n_133M = 1'b0;
    camera_wr_req = 1'b1; vga_rd_req = 1'b1; hdr_rd_req = 1'b1; hdr_wr_req = 1'b1;
    ram_busy = 1'b0; ram_rd_valid = 1'b0; ram_cmd_ack = 1'b0;
    tick(3);
    @(negedge clk_133M);
    checks++; if (ram_cmd_valid !== 1'b0) begin errors++; $display("FAIL reset_cmd_valid got=%b exp=0", ram_cmd_valid); end
    checks++; if (ram_cmd_we !== 1'b0) begin errors++; $display("FAIL reset_cmd_we got=%b exp=0", ram_cmd_we); end
    checks++; if (ram_address !== '0) begin errors++; $display("FAIL reset_address got=%h exp=0", ram_address); end
    checks++; if (ram_wr_data !== '0) begin errors++; $display("FAIL reset_wr_data got=%h exp=0", ram_wr_data); end
    checks++;
    if ({camera_wr_ack, vga_rd_ack, hdr_wr_ack, hdr_rd_ack} !== 4'b0000) begin
      errors++; $display("FAIL reset_acks got=%b exp=0000", {camera_wr_ack, vga_rd_ack, hdr_wr_ack, hdr_rd_ack});
    end
    checks++; if ({vga_rd_valid, hdr_rd_valid, tag_err} !== 3'b000) begin
      errors++; $display("FAIL reset_valid_err got=%b exp=000", {vga_rd_valid, hdr_rd_valid, tag_err});
    end
    do_reset();
  endtask

  task automatic test_priority();
    camera_wr_req = 1'b1; vga_rd_req = 1'b1; hdr_rd_req = 1'b1;
    exp_grant = '{0, 1, 3};
    exp_we    = '{1, 0, 0};
    exp_addr  = '{CAM_A, VGA_A, HDRR_A};
    auto_ack  = 1'b1;
    @(negedge clk_133M);
    checks++; if (ram_cmd_valid !== 1'b0) begin errors++; $display("FAIL prio_latency_n got=%b exp=0", ram_cmd_valid); end
    @(negedge clk_133M);
    checks++; if (ram_cmd_valid !== 1'b1) begin errors++; $display("FAIL prio_latency_n1 got=%b exp=1", ram_cmd_valid); end
    checks++; if (ram_wr_data !== CAM_D) begin errors++; $display("FAIL prio_cam_data got=%h exp=%h", ram_wr_data, CAM_D); end
    wait_grants(3, 60);
    while (exp_grant.size() > 0) begin
      int e = exp_grant.pop_front();
      int g = pop_grant();
      checks++; if (g !== e) begin errors++; $display("FAIL prio_grant got=%0d exp=%0d", g, e); end
    end
    while (exp_we.size() > 0) begin
      int e = exp_we.pop_front();
      logic [ADDR_W-1:0] ea = exp_addr.pop_front();
      int g = (got_we.size() > 0) ? got_we.pop_front() : -1;
      logic [ADDR_W-1:0] ga = (got_addr.size() > 0) ? got_addr.pop_front() : '1;
      checks++; if (g !== e) begin errors++; $display("FAIL prio_we got=%0d exp=%0d", g, e); end
      checks++; if (ga !== ea) begin errors++; $display("FAIL prio_addr got=%h exp=%h", ga, ea); end
    end
    tick(10);
    checks++; if (got_grant.size() != 0) begin errors++; $display("FAIL prio_extra_acks got=%0d exp=0", got_grant.size()); end
    exp_beat = '{1, 0};
    rd_beat(); rd_beat();
    while (exp_beat.size() > 0) begin
      int e = exp_beat.pop_front();
      int g = pop_beat();
      checks++; if (g !== e) begin errors++; $display("FAIL prio_beat got=%0d exp=%0d", g, e); end
    end
    auto_ack = 1'b0;
    got_we.delete(); got_addr.delete();
  endtask

  task automatic test_busy();
    int bad = 0;
    ram_busy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i == 1) hdr_wr_req = 1'b1;
      @(negedge clk_133M);
      if (ram_cmd_valid !== 1'b0) bad++;
      tick(1);
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL busy_hold got=%0d exp=0", bad); end
    ram_busy = 1'b0;
    @(negedge clk_133M);
    checks++; if (ram_cmd_valid !== 1'b0) begin errors++; $display("FAIL busy_release_n got=%b exp=0", ram_cmd_valid); end
    tick(1);
    @(negedge clk_133M);
    checks++; if (ram_cmd_valid !== 1'b1) begin errors++; $display("FAIL busy_valid got=%b exp=1", ram_cmd_valid); end
    checks++; if (ram_address !== HDRW_A) begin errors++; $display("FAIL busy_addr got=%h exp=%h", ram_address, HDRW_A); end
    checks++; if ({ram_cmd_we, ram_wr_data} !== {1'b1, HDRW_D}) begin
      errors++; $display("FAIL busy_we_data got=%b/%h exp=1/%h", ram_cmd_we, ram_wr_data, HDRW_D);
    end
    exp_grant.push_back(2);
    auto_ack = 1'b1;
    wait_grants(1, 20);
    begin
      int e = exp_grant.pop_front();
      int g = pop_grant();
      checks++; if (g !== e) begin errors++; $display("FAIL busy_grant got=%0d exp=%0d", g, e); end
    end
    tick(3);
    auto_ack = 1'b0;
    got_we.delete(); got_addr.delete();
  endtask

  task automatic test_tag_full();
    auto_ack = 1'b1;
    for (int i = 0; i < RD_TAG_DEPTH; i++) begin
      hdr_rd_req = 1'b1;
      exp_grant.push_back(3);
      wait_grants(1, 30);
      begin
        int e = exp_grant.pop_front();
        int g = pop_grant();
        checks++; if (g !== e) begin errors++; $display("FAIL full_fill_grant i=%0d got=%0d exp=%0d", i, g, e); end
      end
    end
    hdr_rd_req = 1'b1;
    tick(8);
    checks++; if (got_grant.size() != 0 || ram_cmd_valid !== 1'b0) begin
      errors++; $display("FAIL full_block_read got=%0d/%b exp=0/0", got_grant.size(), ram_cmd_valid);
    end
    hdr_wr_req = 1'b1;
    exp_grant.push_back(2);
    wait_grants(1, 30);
    begin
      int e = exp_grant.pop_front();
      int g = pop_grant();
      checks++; if (g !== e) begin errors++; $display("FAIL full_write_served got=%0d exp=%0d", g, e); end
    end
    tick(4);
    checks++; if (got_grant.size() != 0) begin errors++; $display("FAIL full_still_blocked got=%0d exp=0", got_grant.size()); end
    exp_beat.push_back(0);
    rd_beat();
    exp_grant.push_back(3);
    wait_grants(1, 30);
    begin
      int e = exp_grant.pop_front();
      int g = pop_grant();
      checks++; if (g !== e) begin errors++; $display("FAIL full_fifth_grant got=%0d exp=%0d", g, e); end
    end
    for (int i = 0; i < RD_TAG_DEPTH; i++) begin
      exp_beat.push_back(0);
      rd_beat();
    end
    while (exp_beat.size() > 0) begin
      int e = exp_beat.pop_front();
      int g = pop_beat();
      checks++; if (g !== e) begin errors++; $display("FAIL full_beat got=%0d exp=%0d", g, e); end
    end
    auto_ack = 1'b0;
    got_we.delete(); got_addr.delete();
  endtask

  task automatic test_interleave();
    int k = 0;
    auto_ack = 1'b1;
    exp_grant = '{3, 1, 3};
    for (int i = 0; i < 3; i++) begin
      if (i == 1) vga_rd_req = 1'b1; else hdr_rd_req = 1'b1;
      wait_grants(1, 30);
      begin
        int e = exp_grant.pop_front();
        int g = pop_grant();
        checks++; if (g !== e) begin errors++; $display("FAIL ilv_grant i=%0d got=%0d exp=%0d", i, g, e); end
      end
    end
    auto_ack = 1'b0;
    tick(2);
    vga_rd_req = 1'b1;
    while (!ram_cmd_valid && k < 20) begin tick(1); k++; end
    checks++; if (ram_cmd_valid !== 1'b1) begin errors++; $display("FAIL ilv_wait_valid got=%b exp=1", ram_cmd_valid); end
    // Controller accepts a read while the oldest beat returns
    exp_beat = '{0, 1, 0, 1};
    ram_cmd_ack = 1'b1; ram_rd_valid = 1'b1;
    tick(1);
    ram_cmd_ack = 1'b0; ram_rd_valid = 1'b0;
    exp_grant.push_back(1);
    wait_grants(1, 10);
    begin
      int e = exp_grant.pop_front();
      int g = pop_grant();
      checks++; if (g !== e) begin errors++; $display("FAIL ilv_pushpop_grant got=%0d exp=%0d", g, e); end
    end
    rd_beat(); rd_beat(); rd_beat();
    while (exp_beat.size() > 0) begin
      int e = exp_beat.pop_front();
      int g = pop_beat();
      checks++; if (g !== e) begin errors++; $display("FAIL ilv_beat got=%0d exp=%0d", g, e); end
    end
    checks++; if (tag_err !== 1'b0) begin errors++; $display("FAIL ilv_no_err got=%b exp=0", tag_err); end
    got_we.delete(); got_addr.delete();
  endtask

  task automatic test_tag_err();
    rd_beat();
    begin
      int g = pop_beat();
      checks++; if (g !== 2) begin errors++; $display("FAIL err_no_valid got=%0d exp=2", g); end
    end
    @(negedge clk_133M);
    checks++; if (tag_err !== 1'b1) begin errors++; $display("FAIL err_set got=%b exp=1", tag_err); end
    tick(5);
    @(negedge clk_133M);
    checks++; if (tag_err !== 1'b1) begin errors++; $display("FAIL err_sticky got=%b exp=1", tag_err); end
    tick(1);
    rst_n_133M = 1'b0;
    tick(1);
    rst_n_133M = 1'b1;
    @(negedge clk_133M);
    checks++; if (tag_err !== 1'b0) begin errors++; $display("FAIL err_cleared got=%b exp=0", tag_err); end
    tick(1);
  endtask

  task automatic test_reset_mid();
    int k = 0;
    auto_ack = 1'b0;
    camera_wr_req = 1'b1;
    while (!ram_cmd_valid && k < 20) begin tick(1); k++; end
    checks++; if (ram_cmd_valid !== 1'b1) begin errors++; $display("FAIL rmid_wait_valid got=%b exp=1", ram_cmd_valid); end
    rst_n_133M = 1'b0;
    tick(1);
    rst_n_133M = 1'b1;
    camera_wr_req = 1'b0;
    @(negedge clk_133M);
    checks++; if (ram_cmd_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid_drop got=%b exp=0", ram_cmd_valid); end
    tick(1);
    ram_cmd_ack = 1'b1;
    tick(1);
    ram_cmd_ack = 1'b0;
    tick(6);
    checks++; if (got_grant.size() != 0) begin errors++; $display("FAIL rmid_no_ack got=%0d exp=0", got_grant.size()); end
  endtask

  task automatic test_rr();
    do_reset();
    hold_reqs = 1'b1;
    camera_wr_req = 1'b1; vga_rd_req = 1'b1; hdr_wr_req = 1'b1; hdr_rd_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
      exp_grant.push_back(i % 4);
`else
      exp_grant.push_back(0);
`endif
    end
    auto_ack = 1'b1;
    wait_grants(8, 120);
    for (int i = 0; i < 8; i++) begin
      int e = exp_grant.pop_front();
      int g = pop_grant();
      checks++; if (g !== e) begin errors++; $display("FAIL rr_grant i=%0d got=%0d exp=%0d", i, g, e); end
    end
    do_reset();
  endtask

  task automatic test_onehot();
    checks++; if (multi_ack != 0) begin errors++; $display("FAIL ack_onehot got=%0d exp=0", multi_ack); end
  endtask

  initial begin
    test_reset();
    test_priority();
    test_busy();
    test_tag_full();
    test_interleave();
    test_tag_err();
    test_reset_mid();
    test_rr();
    test_onehot();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
